// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory data-port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-input winner select: round-robin or fixed priority on contention.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       win_o
);

    // Pick the winning master id from the current request vector.
    always_comb begin
        valid_o = |req_i;
        win_o   = M_CPU;
        if (&req_i) begin
            win_o = (RR != 0) ? ~last_i : M_CPU;
        end else if (req_i[1]) begin
            win_o = M_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the memory data port between CPU and DMA masters.
// Every output is a register loaded from next-state logic.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;

    logic          pick_valid;
    logic          pick_win;

    rr_pick #(.RR(RR)) u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    // State and output registers; reset clears everything except last (=1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= M_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
        end
    end

    // Next state plus next values of the registered outputs; strobes are
    // computed for the cycle being entered, so they line up with the state.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d     = pick_win;
                    last_d   = pick_win;
                    we_d     = pick_win ? m1_we    : m0_we;
                    addr_d   = pick_win ? m1_addr  : m0_addr;
                    wdata_d  = pick_win ? m1_wdata : m0_wdata;
                    gnt_d    = pick_win ? 2'b10 : 2'b01;
                    wr_d     = we_d;
                    rd_d     = ~we_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    rd_d    = 1'b1;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (id_q == M_DMA) begin
                    rdata1_d    = mem_rdata;
                    rvalid_d[1] = 1'b1;
                end else begin
                    rdata0_d    = mem_rdata;
                    rvalid_d[0] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid;
    logic [15:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_mem_read, f_mem_write, f_busy;
    logic [15:0] f_mem_rdata = 16'h0000;

    logic [15:0] mem [0:255];
    logic [15:0] mem_rd_q;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(16), .RR(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(16), .DW(16), .RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt), .m0_rvalid(f_m0_rvalid), .m1_rvalid(f_m1_rvalid),
        .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_read(f_mem_read),
        .mem_write(f_mem_write), .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    // Memory: write on the strobe edge, read registered one cycle.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_read) mem_rd_q <= mem[mem_addr[7:0]];
    end
    assign mem_rdata = mem_rd_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    initial begin
        logic any;
        logic got;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_m1_gnt", m1_gnt, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk16("rst_m0_rdata", m0_rdata, 16'h0000);
        step();
        step();
        rst = 1'b0;

        // Idle for 10 cycles
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            any = any | busy | mem_read | mem_write | m0_gnt | m1_gnt;
        end
        chk1("idle_quiet", any, 1'b0);

        // Single write by m0
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'h00A5;
        step();
        m0_req = 1'b0;
        chk1("wr_m0_gnt", m0_gnt, 1'b1);
        chk1("wr_m1_gnt", m1_gnt, 1'b0);
        chk1("wr_mem_write", mem_write, 1'b1);
        chk1("wr_mem_read", mem_read, 1'b0);
        chk16("wr_mem_addr", mem_addr, 16'h0010);
        chk16("wr_mem_wdata", mem_wdata, 16'h00A5);
        chk1("wr_busy", busy, 1'b1);
        step();
        chk16("wr_mem_content", mem[8'h10], 16'h00A5);
        chk1("wr_busy_after", busy, 1'b0);
        chk1("wr_gnt_pulse", m0_gnt, 1'b0);

        // Single read by m1
        preload(8'h20, 16'h1234);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
        step();
        m1_req = 1'b0;
        chk1("rd_m1_gnt", m1_gnt, 1'b1);
        chk1("rd_mem_read_t1", mem_read, 1'b1);
        chk1("rd_mem_write_t1", mem_write, 1'b0);
        chk16("rd_mem_addr", mem_addr, 16'h0020);
        step();
        chk1("rd_mem_read_t2", mem_read, 1'b1);
        chk1("rd_busy_t2", busy, 1'b1);
        chk1("rd_m1_rvalid_t2", m1_rvalid, 1'b0);
        step();
        chk1("rd_m1_rvalid_t3", m1_rvalid, 1'b1);
        chk16("rd_m1_rdata_t3", m1_rdata, 16'h1234);
        chk1("rd_m0_rvalid_t3", m0_rvalid, 1'b0);
        chk1("rd_busy_t3", busy, 1'b0);
        step();
        chk1("rd_m1_rvalid_t4", m1_rvalid, 1'b0);
        chk16("rd_m1_rdata_hold", m1_rdata, 16'h1234);

        // Contention, both reading continuously, after a fresh reset
        preload(8'h01, 16'h1111);
        preload(8'h02, 16'h2222);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0001;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                step();
                if (m0_gnt || m1_gnt) got = 1'b1;
            end
            chk1("cont_grant_seen", got, 1'b1);
            chk1("cont_rr_m0_gnt", m0_gnt, (k % 2) == 0);
            chk1("cont_rr_m1_gnt", m1_gnt, (k % 2) == 1);
            chk1("cont_fp_m0_gnt", f_m0_gnt, 1'b1);
            chk1("cont_fp_m1_gnt", f_m1_gnt, 1'b0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
        chk1("cont_m1_rvalid", m1_rvalid, 1'b1);
        chk16("cont_m1_rdata", m1_rdata, 16'h2222);
        chk16("cont_m0_rdata_hold", m0_rdata, 16'h1111);
        step();

        // Back-to-back: write then read of the same address by m0
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030; m0_wdata = 16'hBEEF;
        step();
        chk1("b2b_wr_gnt", m0_gnt, 1'b1);
        m0_we = 1'b0;
        step();
        chk1("b2b_gap_gnt", m0_gnt, 1'b0);
        step();
        m0_req = 1'b0;
        chk1("b2b_rd_gnt", m0_gnt, 1'b1);
        chk1("b2b_rd_strobe", mem_read, 1'b1);
        step();
        step();
        chk1("b2b_rvalid", m0_rvalid, 1'b1);
        chk16("b2b_rdata", m0_rdata, 16'hBEEF);
        step();

        // Asynchronous reset while in RDATA
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020;
        step();
        m0_req = 1'b0;
        step();
        chk1("ar_busy_rdata", busy, 1'b1);
        chk1("ar_read_rdata", mem_read, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("ar_busy_now", busy, 1'b0);
        chk1("ar_read_now", mem_read, 1'b0);
        chk1("ar_rvalid_now", m0_rvalid, 1'b0);
        step();
        rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any = any | m0_rvalid | m1_rvalid;
        end
        chk1("ar_no_late_rvalid", any, 1'b0);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0040; m0_wdata = 16'h0001;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0041; m1_wdata = 16'h0002;
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        chk1("ar_post_m0_gnt", m0_gnt, 1'b1);
        chk1("ar_post_m1_gnt", m1_gnt, 1'b0);
        step();
        chk16("ar_post_mem", mem[8'h40], 16'h0001);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the data port of the 256x16 unified memory. It shares the single data-side read/write port between the CPU load/store unit (master 0) and a DMA/loader engine (master 1). It serialises their requests, drives the memory's read/write strobes and address, and returns read data. It also accounts for the memory's one-cycle registered read latency. The top level converts `mem_wdata`/`mem_rdata`/`mem_read` into the memory's tristate data bus.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `RR`, 1, 1 = round-robin on contention, 0 = fixed priority to master 0
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  transaction request; hold until gnt
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req
- `m0_addr`, `m1_addr`  in  AW  address; stable while req
- `m0_wdata`, `m1_wdata`  in  DW  write data; stable while req
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse, request accepted
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse, rdata valid
- `m0_rdata`, `m1_rdata`  out  DW  read data, meaningful only with rvalid
- `mem_addr`  out  AW  to memory `d_addr`
- `mem_wdata`  out  DW  data driven onto memory bus on write
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_rdata`  in  DW  memory bus contents
- `busy`  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE: no requests -> stay. Otherwise pick a winner, latch its id/we/addr/wdata, go to ACCESS.
  - Contention with RR=1: winner = master not granted last.
  - Contention with RR=0: master 0 wins.
- ACCESS: drive `mem_addr` = latched addr. Assert `mem_write` if we, else `mem_read`.
  - Write -> IDLE.
  - Read -> RDATA.
- RDATA: hold `mem_addr` and `mem_read`. Capture `mem_rdata` into the winner's rdata register and set its rvalid for the next cycle. Go to IDLE.
- `last` register updates only on a grant. Reset value is 1, so master 0 wins the first contention.
- Requests are sampled only in IDLE. A req still high in the gnt cycle is ignored. A req still high when the FSM returns to IDLE is treated as a new transaction, so a master drops req on gnt unless it wants another.
- `m*_rdata` holds its last value between rvalids.
- Reset values: state IDLE; all gnt, rvalid, mem_read, mem_write, busy = 0; mem_addr, mem_wdata, rdata = 0; last = 1.
- Reset mid-transaction: outputs clear immediately (asynchronously). A pending read is discarded with no rvalid; a write not yet clocked is dropped.

## Timing
- Request seen in IDLE cycle T:
  - gnt pulse, ACCESS, and mem strobes are in T+1.
  - A write is committed at the T+1 edge.
- Read:
  - Memory registers at the T+1 edge.
  - `mem_rdata` is valid during T+2 (RDATA).
  - rvalid and rdata are presented in T+3.
- Throughput:
  - Write: 2 cycles per transaction (IDLE, ACCESS).
  - Read: 3 cycles per transaction (IDLE, ACCESS, RDATA); rvalid overlaps the next IDLE.
- All outputs are registered; no combinational path from req to gnt.
- `mem_read` and `mem_write` are never high in the same cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, ACCESS, RDATA}
  - master-id constants `M_CPU=0`, `M_DMA=1`
  - default widths
- Sub-module `rr_pick` (2-input winner select from req vector, `last` and RR) is natural. Everything else lives in `mem_arbiter`.

## Test plan
- Single write: m0 writes 0x00A5 to 0x0010 -> m0_gnt in T+1 with mem_write=1, mem_addr=0x0010, mem_wdata=0x00A5. A memory model then reads 0x00A5.
- Single read: preload 0x0020=0x1234, m1 reads 0x0020 -> m1_gnt at T+1, mem_read high T+1..T+2, m1_rvalid at T+3 with 0x1234. m0_rvalid stays 0.
- Contention, RR=1: both hold req for reads of 0x0001/0x0002 after reset -> grants in order m0, m1, m0, m1 while both keep re-requesting. With RR=0: m0 is granted every time while it requests.
- Back-to-back: m0 issues write 0x0030=0xBEEF then read 0x0030 -> rvalid returns 0xBEEF. Transaction starts are 2 cycles apart after the write.
- Async reset asserted during RDATA -> busy, mem_read, and rvalid are 0 immediately. No rvalid appears after reset is released. The next request is granted normally, with m0 winning any contention.
- Simultaneous idle: no req for 10 cycles -> all strobes and gnt stay 0, busy 0.
